// File: rtl/mac_unit_pkg.sv
// mac_unit_pkg
//   Shared constants and operand types for the MAC processing element and
//   the systolic array built from it.
//   - W_BITWIDTH_DEF / IFMAP_BITWIDTH_DEF / OFMAP_BITWIDTH_DEF : default widths
//   - weight_t, ifmap_t, psum_t : signed operand / partial-sum types
package mac_unit_pkg;

  localparam int W_BITWIDTH_DEF     = 8;
  localparam int IFMAP_BITWIDTH_DEF = 16;
  localparam int OFMAP_BITWIDTH_DEF = 32;

  typedef logic signed [W_BITWIDTH_DEF-1:0]     weight_t;
  typedef logic signed [IFMAP_BITWIDTH_DEF-1:0] ifmap_t;
  typedef logic signed [OFMAP_BITWIDTH_DEF-1:0] psum_t;

endpackage

// File: rtl/mac_unit_mul_add.sv
// mac_mul_add
//   Combinational signed multiply-accumulate step: full-precision product of
//   weight and feature map, sign-extended to the partial-sum width, then added
//   to the incoming partial sum with modulo-2^OFMAP_BITWIDTH wrap.
//   Ports:
//     w      in  W_BITWIDTH signed      weight operand
//     ifmap  in  IFMAP_BITWIDTH signed  feature-map operand
//     psum   in  OFMAP_BITWIDTH signed  incoming partial sum
//     sum    out OFMAP_BITWIDTH signed  w*ifmap + psum (wrapping)
module mac_mul_add
  import mac_unit_pkg::*;
#(
  parameter int W_BITWIDTH     = W_BITWIDTH_DEF,
  parameter int IFMAP_BITWIDTH = IFMAP_BITWIDTH_DEF,
  parameter int OFMAP_BITWIDTH = OFMAP_BITWIDTH_DEF
) (
  input  logic signed [W_BITWIDTH-1:0]     w,
  input  logic signed [IFMAP_BITWIDTH-1:0] ifmap,
  input  logic signed [OFMAP_BITWIDTH-1:0] psum,
  output logic signed [OFMAP_BITWIDTH-1:0] sum
);

  localparam int P_BITWIDTH = W_BITWIDTH + IFMAP_BITWIDTH;

  logic signed [P_BITWIDTH-1:0]     prod;
  logic signed [OFMAP_BITWIDTH-1:0] prod_ext;

  // Both operands are signed, so the product is computed signed at the full
  // P_BITWIDTH width; -128 * -32768 = +4194304 fits without loss.
  assign prod     = P_BITWIDTH'(w) * P_BITWIDTH'(ifmap);
  // Sign-extending cast of a signed value up to the partial-sum width.
  assign prod_ext = OFMAP_BITWIDTH'(prod);
  // Plain add: overflow simply wraps, no saturation.
  assign sum      = prod_ext + psum;

endmodule

// File: rtl/mac_unit.sv
// mac_unit
//   One systolic-array processing element. Weight and feature map are
//   registered and forwarded to the neighbouring PE; the accumulate result is
//   computed from the registered operands plus the incoming partial sum, so
//   the partial sum lags the operands by one cycle. No enable and no
//   handshake: every register updates on every rising clock edge.
//   Ports:
//     clk             in   clock, rising edge
//     rst             in   synchronous active-high reset (clears all outputs)
//     w_data_in       in   W_BITWIDTH signed weight
//     ifmap_data_in   in   IFMAP_BITWIDTH signed feature map
//     MAC_data_in     in   OFMAP_BITWIDTH signed incoming partial sum
//     w_data_out      out  registered weight
//     ifmap_data_out  out  registered feature map
//     MAC_data_out    out  registered w_data_out*ifmap_data_out + MAC_data_in
module mac_unit
  import mac_unit_pkg::*;
#(
  parameter int W_BITWIDTH     = W_BITWIDTH_DEF,
  parameter int IFMAP_BITWIDTH = IFMAP_BITWIDTH_DEF,
  parameter int OFMAP_BITWIDTH = OFMAP_BITWIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic signed [W_BITWIDTH-1:0]     w_data_in,
  input  logic signed [IFMAP_BITWIDTH-1:0] ifmap_data_in,
  input  logic signed [OFMAP_BITWIDTH-1:0] MAC_data_in,
  output logic signed [W_BITWIDTH-1:0]     w_data_out,
  output logic signed [IFMAP_BITWIDTH-1:0] ifmap_data_out,
  output logic signed [OFMAP_BITWIDTH-1:0] MAC_data_out
);

  logic signed [OFMAP_BITWIDTH-1:0] mac_next;

  // Multiplies the operands already held in the output registers, which is
  // what produces the one-cycle skew between operands and partial sum.
  mac_mul_add #(
    .W_BITWIDTH     (W_BITWIDTH),
    .IFMAP_BITWIDTH (IFMAP_BITWIDTH),
    .OFMAP_BITWIDTH (OFMAP_BITWIDTH)
  ) u_mul_add (
    .w     (w_data_out),
    .ifmap (ifmap_data_out),
    .psum  (MAC_data_in),
    .sum   (mac_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      w_data_out     <= '0;
      ifmap_data_out <= '0;
      MAC_data_out   <= '0;
    end else begin
      w_data_out     <= w_data_in;
      ifmap_data_out <= ifmap_data_in;
      MAC_data_out   <= mac_next;
    end
  end

endmodule

// File: tb/tb_mac_unit.sv
// tb_mac_unit
//   Scoreboard bench for mac_unit. The driver applies one input vector per
//   cycle, advances a behavioural model of the PE and pushes the expected
//   outputs into exp_q; the monitor pops one entry per cycle and compares.
module tb_mac_unit;
  import mac_unit_pkg::*;

  localparam int WB = W_BITWIDTH_DEF;
  localparam int IB = IFMAP_BITWIDTH_DEF;
  localparam int OB = OFMAP_BITWIDTH_DEF;
  // entry = {spot_en, spot_val, w, ifmap, mac}
  localparam int EW = 1 + OB + WB + IB + OB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  weight_t w_data_in = '0;
  ifmap_t  ifmap_data_in = '0;
  psum_t   MAC_data_in = '0;
  weight_t w_data_out;
  ifmap_t  ifmap_data_out;
  psum_t   MAC_data_out;

  mac_unit dut (
    .clk            (clk),
    .rst            (rst),
    .w_data_in      (w_data_in),
    .ifmap_data_in  (ifmap_data_in),
    .MAC_data_in    (MAC_data_in),
    .w_data_out     (w_data_out),
    .ifmap_data_out (ifmap_data_out),
    .MAC_data_out   (MAC_data_out)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Behavioural model state: what the PE's registers should hold.
  int    m_w  = 0;
  int    m_if = 0;
  psum_t m_mac = '0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One cycle of stimulus. fb=1 feeds the DUT's current MAC_data_out back as
  // MAC_data_in. spot_en adds an independent hand-computed MAC value check.
  task automatic step(input logic r, input int w, input int ifm, input psum_t mac_in,
                      input logic fb, input logic spot_en, input psum_t spot_val);
    longint full;
    psum_t  drv_mac;
    @(negedge clk);
    #1;
    drv_mac       = fb ? MAC_data_out : mac_in;
    rst           = r;
    w_data_in     = weight_t'(w);
    ifmap_data_in = ifmap_t'(ifm);
    MAC_data_in   = drv_mac;
    if (r) begin
      m_w = 0; m_if = 0; m_mac = '0;
    end else begin
      full  = longint'(m_w) * longint'(m_if) + longint'(drv_mac);
      m_mac = full[OB-1:0];
      m_w   = int'(weight_t'(w));
      m_if  = int'(ifmap_t'(ifm));
    end
    exp_q.push_back({spot_en, spot_val, weight_t'(m_w), ifmap_t'(m_if), m_mac});
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("w_data_out", longint'(w_data_out), longint'(weight_t'(e[IB+OB +: WB])));
        check("ifmap_data_out", longint'(ifmap_data_out), longint'(ifmap_t'(e[OB +: IB])));
        check("MAC_data_out", longint'(MAC_data_out), longint'(psum_t'(e[0 +: OB])));
        if (e[EW-1])
          check("MAC_spot", longint'(MAC_data_out), longint'(psum_t'(e[WB+IB+OB +: OB])));
      end
    end
  end

  // Chained accumulation; reset asserted at step index rst_at (-1 = never).
  task automatic chain(input int n, input int rst_at, input logic spots);
    weight_t w;
    ifmap_t  ifm;
    int      tmp;
    int      k;
    psum_t   spot_tab[4];
    spot_tab = '{32'sd0, -32'sd128, 32'sd82, -32'sd246};
    w = -8'sd128; ifm = 16'sd1; k = 0;
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        step(1'b1, 0, 0, '0, 1'b0, 1'b1, '0);
        w = -8'sd128; ifm = 16'sd1; k = 0;
      end else begin
        step(1'b0, int'(w), int'(ifm), '0, (k != 0), spots && (k < 4),
             (k < 4) ? spot_tab[k] : '0);
        w   = w + 8'sd23;
        tmp = int'(ifm) * -2;
        ifm = tmp[IB-1:0];
        k++;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held for 10 cycles with arbitrary inputs.
    for (int i = 0; i < 10; i++)
      step(1'b1, int'($urandom), int'($urandom), psum_t'($urandom), 1'b0, 1'b1, '0);

    // First edge after release: operand registers are zero, so MAC = MAC_data_in.
    step(1'b0, 5, 7, 32'sd12345, 1'b0, 1'b1, 32'sd12345);
    step(1'b1, 0, 0, '0, 1'b0, 1'b1, '0);

    // First operands.
    step(1'b0, -128, 1, '0, 1'b0, 1'b1, 32'sd0);
    step(1'b0, -128, 1, '0, 1'b0, 1'b1, -32'sd128);
    step(1'b1, 0, 0, '0, 1'b0, 1'b0, '0);

    // Chained accumulation, then the same with a mid-stream reset.
    chain(16, -1, 1'b1);
    step(1'b1, 0, 0, '0, 1'b0, 1'b0, '0);
    chain(16, 6, 1'b1);

    // Extreme product.
    step(1'b0, -128, -32768, '0, 1'b0, 1'b0, '0);
    step(1'b0, -128, -32768, '0, 1'b0, 1'b1, 32'sd4194304);

    // Wrap-around of the add.
    step(1'b0, 1, 1, '0, 1'b0, 1'b0, '0);
    step(1'b0, 1, 1, 32'sh7FFFFFFF, 1'b0, 1'b1, psum_t'(32'h80000000));

    // Randomised traffic with occasional resets and feedback.
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 19) == 0), int'($urandom), int'($urandom),
           psum_t'($urandom), $urandom_range(0, 1) == 1, 1'b0, '0);

    // Let the monitor consume the final entry, then confirm nothing was left.
    @(negedge clk);
    #2;
    check("queue_drained", longint'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
